// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected frame capture, error tagging/counting,
// registered read port, sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 P_DATA,
  input  logic                       data_valid,
  input  logic                       par_error,
  input  logic                       stop_error,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [7:0]                 rd_data,
  output logic [1:0]                 rd_err,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_dv_q;
  logic          r_ovf;
  logic [7:0]    r_err_cnt;
  logic [7:0]    r_rd_data;
  logic [1:0]    r_rd_err;
  logic          r_rd_valid;

  logic          w_empty;
  logic          w_full;
  logic          w_wr_req;
  logic          w_err;
  logic          w_store;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_ovf_set;

  // Frame detect, accept/drop decisions and read qualification.
  always_comb begin
    w_empty   = (r_count == CW'(0));
    w_full    = (r_count == CW'(DEPTH));
    w_wr_req  = data_valid & ~r_dv_q;
    w_err     = par_error | stop_error;
    w_store   = w_wr_req & ~(DROP_ERR & w_err);
    w_rd_acc  = rd_en & ~w_empty;
    w_wr_acc  = w_store & (~w_full | w_rd_acc);
    w_ovf_set = w_store & w_full & ~w_rd_acc;
  end

  // Remember previous data_valid so a held level yields one write.
  always_ff @(posedge clk) begin
    if (rst) r_dv_q <= 1'b0;
    else     r_dv_q <= data_valid;
  end

  // Storage array; contents survive reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= {stop_error, par_error, P_DATA};
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
    end
  end

  // Registered read port; data holds between accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_err   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr][7:0];
        r_rd_err  <= r_mem[r_rptr][9:8];
      end
    end
  end

  // Sticky overflow and saturating error counter; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else if (clr_ovf) begin
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_wr_req && w_err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: keep and drop variants run side by side
// against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pdata;
  logic       dv, pe, se, rd, clr;

  logic [7:0] rdd [2];
  logic [1:0] rde [2];
  logic       rdv [2];
  logic       emp [2];
  logic       ful [2];
  logic [3:0] cnt [2];
  logic       ovf [2];
  logic [7:0] ecn [2];

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] mq [2][$];
  logic       m_prev [2];
  logic       m_ovf  [2];
  int         m_ecnt [2];
  logic       m_rv   [2];
  logic [7:0] m_rd   [2];
  logic [1:0] m_re   [2];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b0)) u_keep (
    .clk(clk), .rst(rst), .P_DATA(pdata), .data_valid(dv),
    .par_error(pe), .stop_error(se), .rd_en(rd), .clr_ovf(clr),
    .rd_data(rdd[0]), .rd_err(rde[0]), .rd_valid(rdv[0]),
    .empty(emp[0]), .full(ful[0]), .count(cnt[0]),
    .overflow(ovf[0]), .err_cnt(ecn[0])
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b1)) u_drop (
    .clk(clk), .rst(rst), .P_DATA(pdata), .data_valid(dv),
    .par_error(pe), .stop_error(se), .rd_en(rd), .clr_ovf(clr),
    .rd_data(rdd[1]), .rd_err(rde[1]), .rd_valid(rdv[1]),
    .empty(emp[1]), .full(ful[1]), .count(cnt[1]),
    .overflow(ovf[1]), .err_cnt(ecn[1])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic       edge_;
    logic       err;
    logic       ok;
    logic [9:0] f;
    edge_ = dv && !m_prev[k];
    if (rst) begin
      mq[k].delete();
      m_prev[k] = 1'b0;
      m_ovf[k]  = 1'b0;
      m_ecnt[k] = 0;
      m_rv[k]   = 1'b0;
      m_rd[k]   = 8'h00;
      m_re[k]   = 2'b00;
      return;
    end
    m_prev[k] = dv;
    ok = rd && (mq[k].size() != 0);
    m_rv[k] = ok;
    if (ok) begin
      f = mq[k].pop_front();
      m_rd[k] = f[7:0];
      m_re[k] = f[9:8];
    end
    if (edge_) begin
      err = pe | se;
      if (err && m_ecnt[k] < 255) m_ecnt[k]++;
      if (!(k == 1 && err)) begin
        if (mq[k].size() < DEPTH) mq[k].push_back({se, pe, pdata});
        else m_ovf[k] = 1'b1;
      end
    end
    if (clr) begin
      m_ovf[k]  = 1'b0;
      m_ecnt[k] = 0;
    end
  endtask

  task automatic check_inst(input int k);
    string s;
    s = (k == 0) ? "keep" : "drop";
    chk({s, "_count"}, cnt[k], mq[k].size());
    chk({s, "_empty"}, emp[k], mq[k].size() == 0);
    chk({s, "_full"}, ful[k], mq[k].size() == DEPTH);
    chk({s, "_ovf"}, ovf[k], m_ovf[k]);
    chk({s, "_errcnt"}, ecn[k], m_ecnt[k]);
    chk({s, "_rdvalid"}, rdv[k], m_rv[k]);
    chk({s, "_rddata"}, rdd[k], m_rd[k]);
    chk({s, "_rderr"}, rde[k], m_re[k]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic idle();
    dv = 0; pe = 0; se = 0; rd = 0; clr = 0; rst = 0;
  endtask

  task automatic frame(input logic [7:0] d, input logic p,
                       input logic s, input logic r);
    dv = 1; pdata = d; pe = p; se = s; rd = r;
    cyc();
    dv = 0; pe = 0; se = 0; rd = 0;
    cyc();
  endtask

  task automatic reads(input int n);
    rd = 1;
    repeat (n) cyc();
    rd = 0;
  endtask

  initial begin
    idle();
    pdata = 8'h00;
    rst = 1;
    cyc();
    cyc();
    chk("rst_empty", emp[0], 1);
    rst = 0;
    cyc();

    frame(8'h41, 0, 0, 0);
    frame(8'h42, 0, 0, 0);
    frame(8'h43, 0, 0, 0);
    rd = 1;
    cyc();
    chk("s033_first", rdd[0], 8'h41);
    cyc();
    cyc();
    chk("s033_last", rdd[0], 8'h43);
    rd = 0;
    cyc();
    chk("s033_empty", emp[0], 1);

    dv = 1; pdata = 8'h55;
    repeat (5) cyc();
    dv = 0;
    cyc();
    chk("s034_count", cnt[0], 1);
    reads(2);

    for (int i = 0; i < 9; i++) frame(8'h10 + 8'(i), 0, 0, 0);
    chk("s035_count", cnt[0], 8);
    chk("s035_ovf", ovf[0], 1);
    reads(9);
    clr = 1;
    cyc();
    clr = 0;
    cyc();
    chk("s035_clr", ovf[0], 0);

    frame(8'hA5, 1, 0, 0);
    chk("s036_drop_empty", emp[1], 1);
    chk("s036_errcnt", ecn[0], 1);
    reads(1);
    cyc();
    chk("s036_rderr", rde[0], 2'b01);

    for (int i = 0; i < 8; i++) frame(8'h20 + 8'(i), 0, 0, 0);
    frame(8'hEE, 0, 0, 1);
    chk("s037_count", cnt[0], 8);
    chk("s037_ovf", ovf[0], 0);
    reads(8);
    cyc();
    chk("s037_last", rdd[0], 8'hEE);

    reads(2);
    for (int i = 0; i < 5; i++) frame(8'h60 + 8'(i), 0, 0, 0);
    rst = 1;
    cyc();
    rst = 0;
    chk("s038_rst_count", cnt[0], 0);
    dv = 1; pdata = 8'h77; rst = 1;
    cyc();
    rst = 0;
    repeat (3) cyc();
    dv = 0;
    cyc();
    chk("held_dv_rst", cnt[0], 1);

    for (int i = 0; i < 260; i++)
      frame(8'($urandom), i[0], !i[0], 0);
    chk("errcnt_sat", ecn[0], 255);
    clr = 1; dv = 1; pe = 1; pdata = 8'h99;
    cyc();
    clr = 0; dv = 0; pe = 0;
    cyc();
    reads(DEPTH + 1);

    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = (i / 500) % 2 == 0 ? 4 : 1;
      dv    = $urandom_range(0, 1);
      pdata = 8'($urandom);
      pe    = ($urandom_range(0, 6) == 0);
      se    = ($urandom_range(0, 6) == 0);
      rd    = ($urandom_range(0, rp) == 0);
      clr   = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 255) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
